// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default frame
// geometry also used by the transmitter and the baud divider.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next values: shift the input one stage down the chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Chain registers, preset to the line's idle level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_frame.sv
// UART receive framer: start detect, mid-bit sampling, LSB-first assembly,
// stop-bit check with one-clock valid / framing-error pulses.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | line idle, waiting for rx_s low on a sample tick
//   START | counting to mid start bit; rx_s high there = glitch
//   DATA  | sampling each payload bit at its middle, shifting LSB first
//   STOP  | waiting for mid stop bit, then deliver byte or flag error
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int CNT_W      = $clog2(OVERSAMPLE),
    parameter int BIT_W      = $clog2(DATA_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] TICK_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t              state_d, state_q;
    logic [CNT_W-1:0]       tick_cnt_d, tick_cnt_q;
    logic [BIT_W-1:0]       bit_cnt_d, bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_d, shift_q;
    logic [DATA_BITS-1:0]   data_out_d, data_out_q;
    logic                   data_valid_d, data_valid_q;
    logic                   frame_error_d, frame_error_q;
    logic                   busy_d, busy_q;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame sequencing; everything except the output pulses advances only on ticks.
    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;

        if (sample_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_HALF) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // Returning at mid stop bit lets a back-to-back start edge be seen.
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        if (rx_s) begin
                            data_out_d   = shift_q;
                            data_valid_d = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;

endmodule : uart_rx_frame

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed frames, expectations queued at issue time
// and consumed by a monitor whenever the DUT pulses valid or error.
module tb_uart_rx_frame;

    localparam int OS = 16;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       busy;

    logic       tick_en = 1'b1;
    logic [1:0] div = 2'd0;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    uart_rx_frame dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Tick every 4 clk, changed on the falling edge; frozen while tick_en is low.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_en) begin
                div = div + 2'd1;
                sample_tick = (div == 2'd0);
            end else begin
                sample_tick = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Hold rx at v for n sample ticks; returns just after the n-th tick edge.
    task automatic drive_ticks(input logic v, input int n);
        int cnt;
        cnt = 0;
        rx = v;
        while (cnt < n) begin
            @(posedge clk);
            #1;
            if (sample_tick) cnt++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_ticks(1'b0, OS);
        for (int i = 0; i < 8; i++) drive_ticks(b[i], OS);
        drive_ticks(stop, OS);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_t e;
        e.err = 1'b0;
        e.data = b;
        exp_q.push_back(e);
    endtask

    task automatic expect_err(input logic [7:0] held);
        exp_t e;
        e.err = 1'b1;
        e.data = held;
        exp_q.push_back(e);
    endtask

    initial begin
        fork
            // Monitor: every valid/error pulse must match the head of the queue.
            begin
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (data_valid || frame_error) begin
                        total++;
                        if (data_valid && frame_error) begin
                            bad++;
                            $display("FAIL pulse_excl: valid and error both high, data_out=0x%0h", data_out);
                        end else if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_pulse: valid=%0b err=%0b data_out=0x%0h, none expected",
                                     data_valid, frame_error, data_out);
                        end else begin
                            e = exp_q.pop_front();
                            if (frame_error !== e.err || data_out !== e.data) begin
                                bad++;
                                $display("FAIL frame: got err=%0b data=0x%0h expected err=%0b data=0x%0h",
                                         frame_error, data_out, e.err, e.data);
                            end
                        end
                    end
                end
            end
            // Watchdog.
            begin
                #300000;
                $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values.
        #1;
        check("rst_data_out", data_out, 8'h00);
        check("rst_valid", {7'd0, data_valid}, 8'h00);
        check("rst_error", {7'd0, frame_error}, 8'h00);
        check("rst_busy", {7'd0, busy}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_ticks(1'b1, 20);

        // Reset mid-frame during bit 3 of 0x5A: frame aborted silently.
        drive_ticks(1'b0, OS);
        for (int i = 0; i < 3; i++) drive_ticks(logic'((8'h5A >> i) & 8'h01), OS);
        drive_ticks(1'b1, 5);
        check("midrst_busy_before", {7'd0, busy}, 8'h01);
        reset = 1'b1;
        #1;
        check("midrst_busy", {7'd0, busy}, 8'h00);
        check("midrst_data_out", data_out, 8'h00);
        check("midrst_valid", {7'd0, data_valid}, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        drive_ticks(1'b1, 20);
        expect_byte(8'h5A);
        send_frame(8'h5A, 1'b1);
        drive_ticks(1'b1, 20);

        // Single frame.
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1);
        drive_ticks(1'b1, 20);
        check("a5_busy_after", {7'd0, busy}, 8'h00);

        // Glitch shorter than half a bit.
        drive_ticks(1'b0, 3);
        drive_ticks(1'b1, 4);
        check("glitch_busy_during", {7'd0, busy}, 8'h01);
        drive_ticks(1'b1, 30);
        check("glitch_busy", {7'd0, busy}, 8'h00);
        check("glitch_data_out", data_out, 8'hA5);

        // Framing error: data_out keeps 0xA5.
        expect_err(8'hA5);
        send_frame(8'h3C, 1'b0);
        drive_ticks(1'b1, 30);
        check("ferr_data_out", data_out, 8'hA5);

        // Back-to-back frames, no idle gap.
        expect_byte(8'h00);
        expect_byte(8'hFF);
        expect_byte(8'h81);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h81, 1'b1);
        drive_ticks(1'b1, 20);

        // Tick stall in the middle of bit 3 of 0x6E.
        expect_byte(8'h6E);
        drive_ticks(1'b0, OS);
        for (int i = 0; i < 3; i++) drive_ticks(logic'((8'h6E >> i) & 8'h01), OS);
        drive_ticks(1'b1, 5);
        tick_en = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("stall_busy", {7'd0, busy}, 8'h01);
        tick_en = 1'b1;
        drive_ticks(1'b1, OS - 5);
        for (int i = 4; i < 8; i++) drive_ticks(logic'((8'h6E >> i) & 8'h01), OS);
        drive_ticks(1'b1, OS);
        drive_ticks(1'b1, 20);
        check("stall_data_out", data_out, 8'h6E);

        // Every queued expectation must have been consumed.
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        check("drain_left", 8'(exp_q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx_frame
